// File: rtl/dispensador_troco_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dispensador_troco_if                                              |
// | Change request and coin-ejector handshake bundle.                 |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface dispensador_troco_if;
  logic        troco_req;
  logic [7:0]  valor_troco;
  logic [23:0] moedas_carteira;
  logic        moeda_ack;
  logic        moeda_valid;
  logic [1:0]  moeda_tipo;
  logic        ocupado;
  logic        troco_pronto;
  logic        troco_erro;
  logic [7:0]  troco_faltante;
  logic [23:0] moedas_restantes;

  modport master (
    output troco_req, valor_troco, moedas_carteira, moeda_ack,
    input  moeda_valid, moeda_tipo, ocupado, troco_pronto, troco_erro,
           troco_faltante, moedas_restantes
  );

  modport slave (
    input  troco_req, valor_troco, moedas_carteira, moeda_ack,
    output moeda_valid, moeda_tipo, ocupado, troco_pronto, troco_erro,
           troco_faltante, moedas_restantes
  );
endinterface
`default_nettype wire

// File: rtl/dispensador_troco.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dispensador_troco                                                 |
// | Greedy largest-first change dispenser, one coin per handshake.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dispensador_troco #(
  parameter int D2 = 25,
  parameter int D1 = 5,
  parameter int D0 = 1
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  dispensador_troco_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_d2 = 8'(D2);
  localparam logic [7:0] c_d1 = 8'(D1);
  localparam logic [7:0] c_d0 = 8'(D0);

  state_t      r_state;
  logic [7:0]  r_remaining;
  logic [23:0] r_inventory;
  logic        r_valid;
  logic [1:0]  r_tipo;
  logic        r_pronto;
  logic        r_erro;
  logic [7:0]  r_faltante;

  logic        w_take2;
  logic        w_take1;
  logic        w_take0;
  logic [7:0]  w_coin_val;

  // A type is eligible only if it is in stock and fits, so the subtraction cannot underflow.
  assign w_take2 = (r_inventory[23:16] != 8'd0) && (c_d2 <= r_remaining);
  assign w_take1 = (r_inventory[15:8]  != 8'd0) && (c_d1 <= r_remaining);
  assign w_take0 = (r_inventory[7:0]   != 8'd0) && (c_d0 <= r_remaining);

  always_comb begin
    w_coin_val = c_d0;
    case (r_tipo)
      2'd2:    w_coin_val = c_d2;
      2'd1:    w_coin_val = c_d1;
      default: w_coin_val = c_d0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_remaining <= 8'd0;
      r_inventory <= 24'd0;
      r_valid     <= 1'b0;
      r_tipo      <= 2'd0;
      r_pronto    <= 1'b0;
      r_erro      <= 1'b0;
      r_faltante  <= 8'd0;
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.troco_req) begin
            r_remaining <= bus.valor_troco;
            r_inventory <= bus.moedas_carteira;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          if (w_take2) begin
            r_tipo  <= 2'd2;
            r_valid <= 1'b1;
            r_state <= EJECT;
          end else if (w_take1) begin
            r_tipo  <= 2'd1;
            r_valid <= 1'b1;
            r_state <= EJECT;
          end else if (w_take0) begin
            r_tipo  <= 2'd0;
            r_valid <= 1'b1;
            r_state <= EJECT;
          end else begin
            // Completion results are registered on entry so they are visible during DONE.
            r_pronto   <= 1'b1;
            r_faltante <= r_remaining;
            r_erro     <= (r_remaining != 8'd0);
            r_state    <= DONE;
          end
        end
        EJECT: begin
          if (bus.moeda_ack) begin
            r_remaining <= r_remaining - w_coin_val;
            r_valid     <= 1'b0;
            r_state     <= SELECT;
            case (r_tipo)
              2'd2:    r_inventory[23:16] <= r_inventory[23:16] - 8'd1;
              2'd1:    r_inventory[15:8]  <= r_inventory[15:8]  - 8'd1;
              default: r_inventory[7:0]   <= r_inventory[7:0]   - 8'd1;
            endcase
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.moeda_valid      = r_valid;
  assign bus.moeda_tipo       = r_tipo;
  assign bus.ocupado          = (r_state != IDLE);
  assign bus.troco_pronto     = r_pronto;
  assign bus.troco_erro       = r_erro;
  assign bus.troco_faltante   = r_faltante;
  assign bus.moedas_restantes = r_inventory;

endmodule
`default_nettype wire

// File: tb/tb_dispensador_troco.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dispensador_troco                                              |
// | Directed bench with a greedy change model and per-cycle compare.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_dispensador_troco;

  localparam int c_d2 = 25;
  localparam int c_d1 = 5;
  localparam int c_d0 = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  dispensador_troco_if bus ();

  dispensador_troco #(.D2(c_d2), .D1(c_d1), .D0(c_d0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [1:0]  exp_q[$];
  logic [1:0]  obs[$];
  logic [23:0] model_inv = 24'd0;
  logic [7:0]  model_falt = 8'd0;
  logic [7:0]  exp_rem = 8'd0;
  bit          active = 0;
  bit          done_seen = 0;
  bit          last_erro = 0;
  logic [7:0]  last_falt = 8'd0;
  int          req_cyc = 0;
  int          done_cyc = 0;
  int          last_ack_cyc = 0;
  int          valid_cycles = 0;
  bit          first_valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Greedy payout from the rules: take as many of the largest fitting coin as possible, then smaller.
  task automatic model_start(input logic [7:0] val, input logic [23:0] inv);
    int den[3];
    int cnt[3];
    int rem;
    den = '{c_d0, c_d1, c_d2};
    cnt[0] = int'(inv[7:0]);
    cnt[1] = int'(inv[15:8]);
    cnt[2] = int'(inv[23:16]);
    rem = int'(val);
    exp_q.delete();
    for (int k = 2; k >= 0; k--) begin
      while (cnt[k] > 0 && den[k] <= rem) begin
        exp_q.push_back(2'(k));
        rem -= den[k];
        cnt[k]--;
      end
    end
    exp_rem   = 8'(rem);
    model_inv = inv;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      active = 0;
      exp_q.delete();
      model_inv  = 24'd0;
      model_falt = 8'd0;
      chk("rst_valid", {31'd0, bus.moeda_valid}, 32'd0);
      chk("rst_ocupado", {31'd0, bus.ocupado}, 32'd0);
      chk("rst_pronto", {31'd0, bus.troco_pronto}, 32'd0);
      chk("rst_erro", {31'd0, bus.troco_erro}, 32'd0);
      chk("rst_faltante", {24'd0, bus.troco_faltante}, 32'd0);
      chk("rst_restantes", {8'd0, bus.moedas_restantes}, 32'd0);
    end else begin
      if (active && bus.troco_pronto) model_falt = exp_rem;
      chk("restantes", {8'd0, bus.moedas_restantes}, {8'd0, model_inv});
      chk("faltante", {24'd0, bus.troco_faltante}, {24'd0, model_falt});
      if (!active) begin
        chk("idle_valid", {31'd0, bus.moeda_valid}, 32'd0);
        chk("idle_pronto", {31'd0, bus.troco_pronto}, 32'd0);
        chk("idle_ocupado", {31'd0, bus.ocupado}, 32'd0);
        if (bus.troco_req) begin
          model_start(bus.valor_troco, bus.moedas_carteira);
          active = 1;
          req_cyc = cyc;
          first_valid_seen = 0;
          valid_cycles = 0;
        end
      end else begin
        chk("busy_ocupado", {31'd0, bus.ocupado}, 32'd1);
        if (bus.moeda_valid) begin
          valid_cycles++;
          if (!first_valid_seen) begin
            first_valid_seen = 1;
            chk("req_to_valid", cyc - req_cyc, 32'd2);
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_coin", 32'd1, 32'd0);
          end else begin
            chk("coin_tipo", {30'd0, bus.moeda_tipo}, {30'd0, exp_q[0]});
            if (bus.moeda_ack) begin
              obs.push_back(bus.moeda_tipo);
              model_inv[8*exp_q[0] +: 8] = model_inv[8*exp_q[0] +: 8] - 8'd1;
              void'(exp_q.pop_front());
              last_ack_cyc = cyc;
            end
          end
        end
        if (bus.troco_pronto) begin
          chk("done_no_valid", {31'd0, bus.moeda_valid}, 32'd0);
          chk("done_coins_left", exp_q.size(), 32'd0);
          chk("done_erro", {31'd0, bus.troco_erro}, {31'd0, exp_rem != 8'd0});
          if (obs.size() > 0) chk("ack_to_done", cyc - last_ack_cyc, 32'd2);
          else                chk("req_to_done", cyc - req_cyc, 32'd2);
          last_erro = bus.troco_erro;
          last_falt = bus.troco_faltante;
          done_cyc  = cyc;
          done_seen = 1;
          active    = 0;
        end
      end
    end
  end

  task automatic run_txn(input logic [7:0] val, input logic [23:0] inv, input int stall, input bit busy);
    int wait_cnt;
    int guard;
    obs.delete();
    done_seen = 0;
    @(posedge clock); #1;
    bus.troco_req = 1'b1;
    bus.valor_troco = val;
    bus.moedas_carteira = inv;
    @(posedge clock); #1;
    bus.troco_req = 1'b0;
    wait_cnt = 0;
    guard = 0;
    while (!done_seen && guard < 200) begin
      bus.troco_req = 1'b0;
      if (bus.moeda_valid) begin
        if (busy && wait_cnt == 2) begin
          bus.troco_req = 1'b1;
          bus.valor_troco = 8'd99;
          bus.moedas_carteira = 24'hFFFFFF;
        end
        if (wait_cnt >= stall) begin
          bus.moeda_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.moeda_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.moeda_ack = 1'b0;
      end
      @(posedge clock); #1;
      guard++;
    end
    bus.moeda_ack = 1'b0;
    bus.troco_req = 1'b0;
    if (!done_seen) chk("txn_timeout", 32'd1, 32'd0);
  endtask

  // Coin i of the expected sequence sits in bits [2i+1:2i].
  task automatic chk_obs(input string name, input int n, input logic [15:0] seq);
    chk({name, "_ncoins"}, obs.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_coin"}, (i < obs.size()) ? {30'd0, obs[i]} : 32'hFFFF_FFFF,
          {30'd0, seq[2*i +: 2]});
    end
  endtask

  initial begin
    int guard;
    bus.troco_req = 1'b0;
    bus.valor_troco = 8'd0;
    bus.moedas_carteira = 24'd0;
    bus.moeda_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Full payout
    run_txn(8'd37, {8'd1, 8'd3, 8'd5}, 0, 0);
    chk_obs("full", 5, 16'h0016);
    chk("full_erro", {31'd0, last_erro}, 32'd0);
    chk("full_falt", {24'd0, last_falt}, 32'd0);
    chk("full_rest", {8'd0, bus.moedas_restantes}, 32'h000103);

    // Insufficient inventory
    run_txn(8'd12, {8'd0, 8'd1, 8'd3}, 0, 0);
    chk_obs("short", 4, 16'h0001);
    chk("short_erro", {31'd0, last_erro}, 32'd1);
    chk("short_falt", {24'd0, last_falt}, 32'd4);
    chk("short_rest", {8'd0, bus.moedas_restantes}, 32'h000000);

    // Handshake stall, with an ignored request during EJECT
    run_txn(8'd25, {8'd2, 8'd0, 8'd0}, 5, 1);
    chk_obs("stall", 1, 16'h0002);
    chk("stall_valid_cycles", valid_cycles, 32'd6);
    chk("stall_rest", {8'd0, bus.moedas_restantes}, 32'h010000);
    chk("stall_erro", {31'd0, last_erro}, 32'd0);

    // Zero change
    run_txn(8'd0, {8'd3, 8'd3, 8'd3}, 0, 0);
    chk_obs("zero", 0, 16'h0000);
    chk("zero_latency", done_cyc - req_cyc, 32'd2);
    chk("zero_erro", {31'd0, last_erro}, 32'd0);

    // Skip empty denomination
    run_txn(8'd7, {8'd4, 8'd0, 8'd9}, 0, 0);
    chk_obs("skip", 7, 16'h0000);
    chk("skip_erro", {31'd0, last_erro}, 32'd0);
    chk("skip_rest", {8'd0, bus.moedas_restantes}, 32'h040002);

    // Reset during EJECT
    @(posedge clock); #1;
    bus.troco_req = 1'b1;
    bus.valor_troco = 8'd25;
    bus.moedas_carteira = {8'd2, 8'd0, 8'd0};
    @(posedge clock); #1;
    bus.troco_req = 1'b0;
    guard = 0;
    while (!bus.moeda_valid && guard < 10) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("midrst_reached_eject", {31'd0, bus.moeda_valid}, 32'd1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.moeda_valid}, 32'd0);
    chk("midrst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    chk("midrst_pronto", {31'd0, bus.troco_pronto}, 32'd0);
    chk("midrst_rest", {8'd0, bus.moedas_restantes}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_txn(8'd6, {8'd0, 8'd1, 8'd1}, 0, 0);
    chk_obs("after_rst", 2, 16'h0001);
    chk("after_rst_erro", {31'd0, last_erro}, 32'd0);
    chk("after_rst_rest", {8'd0, bus.moedas_restantes}, 32'h000000);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispensador_troco.md
Name: dispensador_troco

Overview:
- Change-dispensing responder on the other end of the vending machine's change interface.
- Accepts a change request and the wallet coin inventory from `vm`.
- Ejects coins one at a time to the coin-ejector mechanism over a valid/ack handshake, greedy largest-first.
- Reports completion, any undispensable remainder, and the updated inventory.

Parameters:
- D2, 25, value of coin type 2 (largest)
- D1, 5, value of coin type 1
- D0, 1, value of coin type 0 (smallest); D2 > D1 > D0 > 0, all ≤ 255

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- troco_req  input  1  one-cycle request to start dispensing; sampled only in IDLE
- valor_troco  input  8  change amount, latched with troco_req
- moedas_carteira  input  24  inventory latched with troco_req: [23:16] count D2, [15:8] count D1, [7:0] count D0
- moeda_ack  input  1  ejector accepted the presented coin
- moeda_valid  output  1  a coin is presented for ejection
- moeda_tipo  output  2  type of presented coin (2/1/0); 3 never driven
- ocupado  output  1  high in every state except IDLE
- troco_pronto  output  1  one-cycle completion pulse
- troco_erro  output  1  valid with troco_pronto: 1 = remainder could not be paid
- troco_faltante  output  8  unpaid remainder, updated at DONE, held until next DONE
- moedas_restantes  output  24  internal inventory (same packing), updated on every ack

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State=IDLE.
  - All outputs 0; internal remaining and inventory registers 0.
  - Reset mid-operation abandons the transaction immediately; no troco_pronto is issued.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE:
  - On troco_req=1: latch remaining←valor_troco and inventory←moedas_carteira; moedas_restantes follows the latched inventory.
  - Next state SELECT (including valor_troco=0).
  - troco_req while not in IDLE is ignored and not queued.
- SELECT (exactly 1 cycle):
  - Choose the highest type k with count_k>0 and Dk ≤ remaining.
  - If found: register moeda_tipo=k, moeda_valid=1, go EJECT.
  - Else go DONE.
- EJECT:
  - moeda_valid and moeda_tipo stay stable until a cycle with moeda_ack=1.
  - On that edge: remaining←remaining−Dk, count_k←count_k−1, moeda_valid←0, go SELECT.
  - moeda_ack outside EJECT is ignored.
  - Ack in the first cycle valid is high is legal. Minimum cost is 2 cycles per coin.
  - No timeout; EJECT waits indefinitely.
- DONE (1 cycle):
  - troco_pronto=1 and troco_faltante←remaining.
  - troco_erro←(remaining≠0).
  - Next state IDLE.
- Latency:
  - troco_req to first moeda_valid: 2 cycles.
  - Last ack to troco_pronto: 2 cycles (SELECT, then DONE).
  - valor_troco=0: troco_pronto 2 cycles after request, erro=0, no coins.
- Arithmetic: subtraction never underflows, because selection requires Dk ≤ remaining. Counts never decrement below 0.
- Greedy only: no backtracking. With D=25/5/1, an out-of-fives case falls back to ones; an empty inventory gives erro.

Test Plan:
- Full payout: valor_troco=37, moedas_carteira={8'd1,8'd3,8'd5}, ack same cycle → coins 2,1,1,0,0; troco_pronto with erro=0, faltante=0; moedas_restantes={0,1,3}.
- Insufficient inventory: valor_troco=12, inventory {0,1,3} → coins 1,0,0,0; then troco_pronto, erro=1, faltante=4, moedas_restantes={0,0,0}.
- Handshake stall: valor_troco=25, inventory {2,0,0}, moeda_ack held low 5 cycles → moeda_valid=1, moeda_tipo=2 stable for all 5; single ejection on ack; restantes={1,0,0}.
- Zero/busy: troco_req with valor_troco=0 → no moeda_valid, troco_pronto 2 cycles later, erro=0. A second troco_req during EJECT of another transaction → ignored, latched values unchanged.
- Reset mid-operation: reset_n low during EJECT → moeda_valid, ocupado, troco_pronto drop at once, all outputs 0. After release, a new request of 6 with {0,1,1} → coins 1,0 and a clean completion.
- Skip denomination: valor_troco=7, inventory {4,0,9} → seven type-0 coins, erro=0, restantes={4,0,2}.
